// File: rtl/telemetry_frame_tx.sv
// -----------------------------------------------------------------------------
// telemetry_frame_tx
//
// Serialises one telemetry frame onto an 8N1 UART line for the flight
// controller's receiver. Word order: START_CODE, pos_x, pos_y, pos_z, vel_x,
// vel_y, vel_z (plus an XOR checksum word when TELEMETRY_CHECKSUM_EN is
// defined). Each word goes out most significant byte first; each byte goes
// out LSB first as start bit, 8 data bits, stop bit, then GAP_BITS mark bits.
//
// Build option:
//   TELEMETRY_CHECKSUM_EN  append w7 = w1 ^ w2 ^ ... ^ w6 (32-byte frame)
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
//   START_CODE    frame header word
//   GAP_BITS      idle mark bit-times after every stop bit (0 allowed)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   frame_valid  frame words valid (accepted when frame_ready is high)
//   frame_ready  idle, a frame will be accepted on this edge
//   pos_x/y/z    position words, sent unmodified
//   vel_x/y/z    signed velocity words, sent unmodified
//   tx           UART line, idle high
//   busy         frame in flight
//   done         one-cycle pulse after the final bit period of a frame
//   collide      one-cycle pulse after acceptance when a data word equals
//                START_CODE (the frame is still sent unchanged)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module telemetry_frame_tx #(
   parameter int          CLKS_PER_BIT = 868,
   parameter logic [31:0] START_CODE   = 32'hAAAA_AAAA,
   parameter int          GAP_BITS     = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_valid,
   output logic               frame_ready,
   input  logic [31:0]        pos_x,
   input  logic [31:0]        pos_y,
   input  logic [31:0]        pos_z,
   input  logic signed [31:0] vel_x,
   input  logic signed [31:0] vel_y,
   input  logic signed [31:0] vel_z,
   output logic               tx,
   output logic               busy,
   output logic               done,
   output logic               collide
);

   localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] GAP_LAST = (GAP_BITS > 0) ? 16'(GAP_BITS - 1) : 16'd0;

`ifdef TELEMETRY_CHECKSUM_EN
   localparam logic [2:0] LAST_WORD = 3'd7;
`else
   localparam logic [2:0] LAST_WORD = 3'd6;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_START_BIT,
      S_DATA_BITS,
      S_STOP_BIT,
      S_GAP
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] timer_reg, timer_next;
   logic [2:0]  bit_idx_reg, bit_idx_next;
   logic [15:0] gap_reg, gap_next;
   logic [1:0]  byte_idx_reg, byte_idx_next;
   logic [2:0]  word_idx_reg, word_idx_next;
   logic        tx_reg, tx_next;
   logic        done_reg, done_next;
   logic        collide_reg, collide_next;

   logic        load;
   logic        bit_end;
   logic        byte_end;
   logic [31:0] word_sel;

   // Frame data words 1..6, latched on acceptance.
   logic [31:0] word_in  [1:6];
   logic [31:0] word_val [1:6];
   logic [6:1]  code_hit;

   assign word_in[1] = pos_x;
   assign word_in[2] = pos_y;
   assign word_in[3] = pos_z;
   assign word_in[4] = vel_x;
   assign word_in[5] = vel_y;
   assign word_in[6] = vel_z;

   genvar gi;
   generate
      for (gi = 1; gi <= 6; gi++) begin : g_word
         logic [31:0] word_reg;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               word_reg <= '0;
            end else if (load) begin
               word_reg <= word_in[gi];
            end
         end

         assign word_val[gi] = word_reg;
         assign code_hit[gi] = (word_in[gi] == START_CODE);
      end
   endgenerate

`ifdef TELEMETRY_CHECKSUM_EN
   logic [31:0] checksum;

   always_comb begin
      checksum = '0;
      for (int i = 1; i <= 6; i++) begin
         checksum = checksum ^ word_val[i];
      end
   end
`endif

   // State and counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= S_IDLE;
         timer_reg    <= '0;
         bit_idx_reg  <= '0;
         gap_reg      <= '0;
         byte_idx_reg <= '0;
         word_idx_reg <= '0;
         tx_reg       <= 1'b1;
         done_reg     <= 1'b0;
         collide_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         timer_reg    <= timer_next;
         bit_idx_reg  <= bit_idx_next;
         gap_reg      <= gap_next;
         byte_idx_reg <= byte_idx_next;
         word_idx_reg <= word_idx_next;
         tx_reg       <= tx_next;
         done_reg     <= done_next;
         collide_reg  <= collide_next;
      end
   end

   assign bit_end = (timer_reg == BIT_LAST);

   // Next-state logic
   always_comb begin
      state_next    = state_reg;
      timer_next    = timer_reg;
      bit_idx_next  = bit_idx_reg;
      gap_next      = gap_reg;
      byte_idx_next = byte_idx_reg;
      word_idx_next = word_idx_reg;
      load          = 1'b0;
      byte_end      = 1'b0;
      done_next     = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (frame_valid) begin
               load          = 1'b1;
               state_next    = S_START_BIT;
               timer_next    = '0;
               bit_idx_next  = '0;
               gap_next      = '0;
               byte_idx_next = 2'd3;
               word_idx_next = '0;
            end
         end
         S_START_BIT: begin
            if (bit_end) begin
               state_next   = S_DATA_BITS;
               bit_idx_next = '0;
            end
         end
         S_DATA_BITS: begin
            if (bit_end) begin
               if (bit_idx_reg == 3'd7) begin
                  state_next = S_STOP_BIT;
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
               end
            end
         end
         S_STOP_BIT: begin
            if (bit_end) begin
               if (GAP_BITS == 0) begin
                  byte_end = 1'b1;
               end else begin
                  state_next = S_GAP;
                  gap_next   = '0;
               end
            end
         end
         S_GAP: begin
            if (bit_end) begin
               if (gap_reg == GAP_LAST) begin
                  byte_end = 1'b1;
               end else begin
                  gap_next = gap_reg + 16'd1;
               end
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Bit timer free-runs across every bit period of the frame.
      if (state_reg != S_IDLE) begin
         timer_next = bit_end ? 16'd0 : timer_reg + 16'd1;
      end

      // End of a byte: step to the next byte (3 -> 0 wraps to 3 and bumps
      // the word index), or finish after the last byte of the last word.
      if (byte_end) begin
         if ((byte_idx_reg == 2'd0) && (word_idx_reg == LAST_WORD)) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
         end else begin
            state_next    = S_START_BIT;
            byte_idx_next = byte_idx_reg - 2'd1;
            if (byte_idx_reg == 2'd0) begin
               word_idx_next = word_idx_reg + 3'd1;
            end
         end
      end

      collide_next = load && (|code_hit);
   end

   // Word selected by the indices that will be current next cycle, so the
   // registered tx carries the bit for the state being entered.
   always_comb begin
      word_sel = START_CODE;
      case (word_idx_next)
         3'd1:    word_sel = word_val[1];
         3'd2:    word_sel = word_val[2];
         3'd3:    word_sel = word_val[3];
         3'd4:    word_sel = word_val[4];
         3'd5:    word_sel = word_val[5];
         3'd6:    word_sel = word_val[6];
`ifdef TELEMETRY_CHECKSUM_EN
         3'd7:    word_sel = checksum;
`endif
         default: word_sel = START_CODE;
      endcase
   end

   always_comb begin
      tx_next = 1'b1;
      case (state_next)
         S_START_BIT: tx_next = 1'b0;
         S_DATA_BITS: tx_next = word_sel[{byte_idx_next, bit_idx_next}];
         default:     tx_next = 1'b1;
      endcase
   end

   assign tx          = tx_reg;
   assign done        = done_reg;
   assign collide     = collide_reg;
   assign busy        = (state_reg != S_IDLE);
   assign frame_ready = (state_reg == S_IDLE);

endmodule

// File: tb/tb_telemetry_frame_tx.sv
`timescale 1ns/1ps
module tb_telemetry_frame_tx;

   localparam int CPB      = 4;
   localparam int GAP      = 1;
   localparam int BYTE_CYC = (10 + GAP) * CPB;
`ifdef TELEMETRY_CHECKSUM_EN
   localparam int NWORDS   = 8;
`else
   localparam int NWORDS   = 7;
`endif
   localparam int NBYTES    = NWORDS * 4;
   localparam int FRAME_CYC = NBYTES * BYTE_CYC;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               frame_valid = 1'b0;
   logic               frame_ready;
   logic [31:0]        pos_x = '0, pos_y = '0, pos_z = '0;
   logic signed [31:0] vel_x = '0, vel_y = '0, vel_z = '0;
   logic               tx, busy, done, collide;

   telemetry_frame_tx #(
      .CLKS_PER_BIT (CPB),
      .START_CODE   (32'hAAAA_AAAA),
      .GAP_BITS     (GAP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .pos_x       (pos_x),
      .pos_y       (pos_y),
      .pos_z       (pos_z),
      .vel_x       (vel_x),
      .vel_y       (vel_y),
      .vel_z       (vel_z),
      .tx          (tx),
      .busy        (busy),
      .done        (done),
      .collide     (collide)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] px, py, pz, vx, vy, vz;
      logic [31:0] csum;   // hand-computed XOR of the six data words
      logic        coll;   // a data word equals the start code
   } vec_t;

   vec_t vecs [4];
   vec_t next_v;
   logic keep_valid = 1'b0;
   logic have_next  = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   int done_total = 0;

   logic tx_s      [0:FRAME_CYC];
   logic done_s    [0:FRAME_CYC];
   logic busy_s    [0:FRAME_CYC];
   logic ready_s   [0:FRAME_CYC];
   logic collide_s [0:FRAME_CYC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      pos_x = v.px; pos_y = v.py; pos_z = v.pz;
      vel_x = v.vx; vel_y = v.vy; vel_z = v.vz;
      frame_valid = 1'b1;
   endtask

   task automatic scramble();
      pos_x = $urandom; pos_y = $urandom; pos_z = $urandom;
      vel_x = $urandom; vel_y = $urandom; vel_z = $urandom;
   endtask

   // Samples every cycle from the first cycle after acceptance (c=0) up to
   // and including the cycle where done is due (c=FRAME_CYC).
   task automatic capture();
      for (int c = 0; c <= FRAME_CYC; c++) begin
         @(negedge clk);
         tx_s[c]      = tx;
         done_s[c]    = done;
         busy_s[c]    = busy;
         ready_s[c]   = frame_ready;
         collide_s[c] = collide;
         if (done === 1'b1) done_total++;
         if (c == 0) begin
            scramble();
            if (!keep_valid) frame_valid = 1'b0;
         end
         if ((c == FRAME_CYC) && have_next) drive(next_v);
      end
   endtask

   task automatic check_frame(input vec_t v, input int id);
      logic [31:0] w [8];
      logic [7:0]  b;
      logic [10:0] exp_f, act_f;
      int          bad, early_done, extra_coll;
      w[0] = 32'hAAAA_AAAA;
      w[1] = v.px; w[2] = v.py; w[3] = v.pz;
      w[4] = v.vx; w[5] = v.vy; w[6] = v.vz;
      w[7] = v.csum;
      bad = 0;
      for (int k = 0; k < NBYTES; k++) begin
         b     = w[k / 4][(3 - (k % 4)) * 8 +: 8];
         exp_f = {2'b11, b, 1'b0};
         for (int j = 0; j < 11; j++) begin
            act_f[j] = tx_s[k * BYTE_CYC + j * CPB + CPB / 2];
            for (int s = 0; s < CPB; s++) begin
               if (tx_s[k * BYTE_CYC + j * CPB + s] !== exp_f[j]) bad++;
            end
         end
         check($sformatf("v%0d_byte%0d", id, k), 32'(act_f), 32'(exp_f));
      end
      check($sformatf("v%0d_bit_cycles_wrong", id), 32'(bad), 32'd0);
      early_done = 0;
      extra_coll = 0;
      for (int c = 0; c < FRAME_CYC; c++) begin
         if (done_s[c] !== 1'b0) early_done++;
         if ((c > 0) && (collide_s[c] !== 1'b0)) extra_coll++;
      end
      check($sformatf("v%0d_early_done", id), 32'(early_done), 32'd0);
      check($sformatf("v%0d_done_at_end", id), 32'(done_s[FRAME_CYC]), 32'd1);
      check($sformatf("v%0d_busy_end", id), 32'(busy_s[FRAME_CYC]), 32'd0);
      check($sformatf("v%0d_ready_end", id), 32'(ready_s[FRAME_CYC]), 32'd1);
      check($sformatf("v%0d_busy_start", id), 32'(busy_s[0]), 32'd1);
      check($sformatf("v%0d_ready_start", id), 32'(ready_s[0]), 32'd0);
      check($sformatf("v%0d_collide", id), 32'(collide_s[0]), 32'(v.coll));
      check($sformatf("v%0d_collide_extra", id), 32'(extra_coll), 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input int id);
      @(negedge clk);
      check($sformatf("v%0d_ready_pre", id), 32'(frame_ready), 32'd1);
      drive(v);
      keep_valid = 1'b0;
      have_next  = 1'b0;
      capture();
      check_frame(v, id);
   endtask

   initial begin
      int act_cnt;

      // Spec frame, collide frame, mixed bit patterns, and 1..6.
      vecs[0] = '{px: 32'd100, py: 32'd200, pz: 32'd300,
                  vx: 32'hFFFF_FFFB, vy: 32'd0, vz: 32'd7,
                  csum: 32'hFFFF_FE7C, coll: 1'b0};
      vecs[1] = '{px: 32'd1, py: 32'hAAAA_AAAA, pz: 32'd3,
                  vx: 32'd4, vy: 32'd5, vz: 32'd6,
                  csum: 32'hAAAA_AAAF, coll: 1'b1};
      vecs[2] = '{px: 32'h1234_5678, py: 32'h8000_0001, pz: 32'h0000_0000,
                  vx: 32'hDEAD_BEEF, vy: 32'hFFFF_FFFF, vz: 32'h7FFF_FFFF,
                  csum: 32'hCC99_E896, coll: 1'b0};
      vecs[3] = '{px: 32'd1, py: 32'd2, pz: 32'd3,
                  vx: 32'd4, vy: 32'd5, vz: 32'd6,
                  csum: 32'h0000_0007, coll: 1'b0};

      // Reset held for three cycles
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_ready", 32'(frame_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_collide", 32'(collide), 32'd0);
      rst = 1'b1;
      act_cnt = 0;
      repeat (100) begin
         @(negedge clk);
         if ((tx !== 1'b1) || (frame_ready !== 1'b1) || (busy !== 1'b0) ||
             (done !== 1'b0) || (collide !== 1'b0)) act_cnt++;
      end
      check("idle_activity", 32'(act_cnt), 32'd0);

      // Table of single frames
      for (int i = 0; i < 4; i++) begin
         run_vec(vecs[i], i);
      end

      // Back-to-back: frame_valid held high across two frames; the second
      // is accepted in the done cycle of the first.
      @(negedge clk);
      drive(vecs[3]);
      keep_valid = 1'b1;
      have_next  = 1'b1;
      next_v     = vecs[0];
      done_total = 0;
      capture();
      check_frame(vecs[3], 10);
      keep_valid = 1'b0;
      have_next  = 1'b0;
      capture();
      check_frame(vecs[0], 11);
      check("b2b_done_count", 32'(done_total), 32'd2);

      // Reset during the start bit of w3 byte 1 (frame byte 14)
      @(negedge clk);
      drive(vecs[2]);
      for (int c = 0; c <= 14 * BYTE_CYC + 1; c++) begin
         @(negedge clk);
         if (c == 0) begin
            scramble();
            frame_valid = 1'b0;
         end
      end
      check("mid_pre_tx", 32'(tx), 32'd0);
      rst = 1'b0;
      #1;
      check("mid_rst_tx", 32'(tx), 32'd1);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ready", 32'(frame_ready), 32'd1);
      act_cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if ((done !== 1'b0) || (tx !== 1'b1)) act_cnt++;
      end
      rst = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if ((done !== 1'b0) || (tx !== 1'b1) || (busy !== 1'b0)) act_cnt++;
      end
      check("mid_rst_quiet", 32'(act_cnt), 32'd0);
      run_vec(vecs[1], 20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
